// File: rtl/apb_reg_pkg.sv
// Shared types and decode helpers for the APB register slaves.
// Index and error rules live here so every slave decodes addresses the same way.
package apb_reg_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int WAIT_CNT_W = 4;

  function automatic logic [29:0] reg_index(input logic [31:0] paddr);
    return paddr[31:2];
  endfunction

  // Unaligned, unmapped, or a write that lands on a read-only status word.
  function automatic logic is_err(input logic [29:0] index, input logic pwrite,
                                  input logic aligned, input int unsigned n_rw,
                                  input int unsigned n_ro);
    return !aligned || (32'(index) >= n_rw + n_ro) || (pwrite && (32'(index) >= n_rw));
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational APB word-address decode: register index, alignment, region and error flags.
module apb_addr_decode
  import apb_reg_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int N_RW   = 4,
  parameter int N_RO   = 2
) (
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  output logic [ADDR_W-3:0] index,
  output logic              aligned,
  output logic              is_rw,
  output logic              is_ro,
  output logic              err
);

  logic [29:0] idx_full;

  assign idx_full = reg_index(32'(paddr));
  assign index    = idx_full[ADDR_W-3:0];
  assign aligned  = (paddr[1:0] == 2'b00);
  // Region flags look only at the index; alignment is reported separately.
  assign is_rw    = (idx_full < 30'(N_RW));
  assign is_ro    = !is_rw && (idx_full < 30'(N_RW + N_RO));
  assign err      = is_err(idx_full, pwrite, aligned, N_RW, N_RO);

endmodule

// File: rtl/apb_reg_slave.sv
// Parametrised APB4 register slave: RW control words with byte strobes, RO status words,
// programmable wait states and decoded pslverr.
module apb_reg_slave
  import apb_reg_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 32,
  parameter int                N_RW        = 4,
  parameter int                N_RO        = 2,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [DATA_W-1:0] RW_RESET    = '0
) (
  input  logic                   pclk,
  input  logic                   preset_n,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [ADDR_W-1:0]      paddr,
  input  logic [DATA_W-1:0]      pwdata,
  input  logic [DATA_W/8-1:0]    pstrb,
  output logic [DATA_W-1:0]      prdata,
  output logic                   pready,
  output logic                   pslverr,
  input  logic [N_RO*DATA_W-1:0] ro_status,
  output logic [N_RW*DATA_W-1:0] rw_regs,
  output logic [N_RW-1:0]        wr_pulse
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int NB    = DATA_W / 8;

  state_t                      state_q, state_d;
  logic [WAIT_CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q;
  logic                        write_q, err_q, aligned_q, is_rw_q, is_ro_q;
  logic [NB-1:0]               strb_q;
  logic [DATA_W-1:0]           wdata_q;
  logic [N_RW-1:0][DATA_W-1:0] rw_q;
  logic [N_RO-1:0][DATA_W-1:0] ro_v;
  logic [N_RW-1:0]             wr_pulse_q;
  logic [DATA_W-1:0]           rdata;
  logic                        latch, commit, ready_w;

  logic [IDX_W-1:0] dec_index;
  logic             dec_aligned, dec_is_rw, dec_is_ro, dec_err;

  apb_addr_decode #(
    .ADDR_W (ADDR_W),
    .N_RW   (N_RW),
    .N_RO   (N_RO)
  ) u_decode (
    .paddr   (paddr),
    .pwrite  (pwrite),
    .index   (dec_index),
    .aligned (dec_aligned),
    .is_rw   (dec_is_rw),
    .is_ro   (dec_is_ro),
    .err     (dec_err)
  );

  assign ro_v    = ro_status;
  assign ready_w = (state_q == ACCESS) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        // psel && penable with no setup phase is a protocol violation and is ignored.
        if (psel && !penable) begin
          latch   = 1'b1;
          cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (ready_w) begin
            state_d = IDLE;
            commit  = write_q && !err_q;
          end else begin
            cnt_d = cnt_q - WAIT_CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      aligned_q  <= 1'b0;
      is_rw_q    <= 1'b0;
      is_ro_q    <= 1'b0;
      strb_q     <= '0;
      wdata_q    <= '0;
      wr_pulse_q <= '0;
      for (int k = 0; k < N_RW; k++) rw_q[k] <= RW_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        idx_q     <= dec_index;
        write_q   <= pwrite;
        err_q     <= dec_err;
        aligned_q <= dec_aligned;
        is_rw_q   <= dec_is_rw;
        is_ro_q   <= dec_is_ro;
        strb_q    <= pstrb;
        wdata_q   <= pwdata;
      end
      // wr_pulse fires on every committed write, even with all strobes low.
      for (int k = 0; k < N_RW; k++) begin
        wr_pulse_q[k] <= commit && (idx_q == IDX_W'(k));
        for (int b = 0; b < NB; b++) begin
          if (commit && (idx_q == IDX_W'(k)) && strb_q[b])
            rw_q[k][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end
    end
  end

  // Status words are read live so the value on the completion cycle is returned.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < N_RW; k++)
      if (aligned_q && is_rw_q && (idx_q == IDX_W'(k))) rdata = rw_q[k];
    for (int k = 0; k < N_RO; k++)
      if (aligned_q && is_ro_q && (idx_q == IDX_W'(N_RW + k))) rdata = ro_v[k];
  end

  assign pready   = ready_w;
  assign pslverr  = ready_w && err_q;
  assign prdata   = (ready_w && !write_q && !err_q) ? rdata : '0;
  assign rw_regs  = rw_q;
  assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: a 2-wait-state instance and a zero-wait instance sharing one bus.
module tb_apb_reg_slave;

  logic        clk = 1'b0;
  logic        preset_n = 1'b0;
  logic        psel_a = 1'b0, psel_b = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [63:0] ro_status = {32'h5A5A_0002, 32'hA5A5_0001};

  logic [31:0]       prdata_a, prdata_b;
  logic              pready_a, pready_b, pslverr_a, pslverr_b;
  logic [3:0][31:0]  rw_a, rw_b;
  logic [3:0]        wr_pulse_a, wr_pulse_b;

  logic [3:0][31:0]  mdl_a = '0, mdl_b = '0;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  pulse;
    logic [7:0]  lat;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rd;
    bit          err;
    logic [3:0]  pulse;
  } vec_t;
  vec_t vecs[13];

  always #5 clk = ~clk;

  apb_reg_slave #(.WAIT_CYCLES(2)) dut_a (
    .pclk(clk), .preset_n(preset_n), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a), .pready(pready_a),
    .pslverr(pslverr_a), .ro_status(ro_status), .rw_regs(rw_a), .wr_pulse(wr_pulse_a)
  );

  apb_reg_slave #(.WAIT_CYCLES(0)) dut_b (
    .pclk(clk), .preset_n(preset_n), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_b), .pready(pready_b),
    .pslverr(pslverr_b), .ro_status(ro_status), .rw_regs(rw_b), .wr_pulse(wr_pulse_b)
  );

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  task automatic apb(input bit b, input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                     input logic [3:0] st, input logic [31:0] exp_rd, input bit exp_err,
                     input logic [3:0] exp_pulse, input int exp_lat);
    exp_t e;
    int   cyc;
    int   idx;
    sbq.push_back('{exp_rd, exp_err, exp_pulse, 8'(exp_lat)});
    @(posedge clk); #1;
    if (b) psel_b = 1'b1; else psel_a = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
    @(posedge clk); #1 penable = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      if ((b ? pready_b : pready_a) || cyc > 40) break;
      cyc++;
    end
    e = sbq.pop_front();
    chk("latency", 128'(cyc), 128'(e.lat));
    chk("prdata", b ? prdata_b : prdata_a, e.rdata);
    chk("pslverr", b ? pslverr_b : pslverr_a, e.err);
    @(posedge clk); #1 psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("wr_pulse", b ? wr_pulse_b : wr_pulse_a, e.pulse);
    if (wr && !exp_err) begin
      idx = int'(addr[7:2]);
      for (int i = 0; i < 4; i++)
        if (st[i]) begin
          if (b) mdl_b[idx][i*8 +: 8] = wd[i*8 +: 8];
          else   mdl_a[idx][i*8 +: 8] = wd[i*8 +: 8];
        end
    end
    chk("rw_regs", b ? rw_b : rw_a, b ? mdl_b : mdl_a);
  endtask

  initial begin
    //           wr addr   wdata         strb  exp prdata    err pulse
    vecs[0]  = '{1, 8'h04, 32'hDEADBEEF, 4'hF, 32'h0,        0, 4'b0010};
    vecs[1]  = '{1, 8'h04, 32'h11223344, 4'h5, 32'h0,        0, 4'b0010};
    vecs[2]  = '{0, 8'h04, 32'h0,        4'h0, 32'hDE22BE44, 0, 4'b0000};
    vecs[3]  = '{0, 8'h10, 32'h0,        4'h0, 32'hA5A50001, 0, 4'b0000};
    vecs[4]  = '{1, 8'h10, 32'h12345678, 4'hF, 32'h0,        1, 4'b0000};
    vecs[5]  = '{0, 8'h18, 32'h0,        4'h0, 32'h0,        1, 4'b0000};
    vecs[6]  = '{0, 8'h05, 32'h0,        4'h0, 32'h0,        1, 4'b0000};
    vecs[7]  = '{0, 8'h14, 32'h0,        4'h0, 32'h5A5A0002, 0, 4'b0000};
    vecs[8]  = '{1, 8'h00, 32'hFFFFFFFF, 4'h0, 32'h0,        0, 4'b0001};
    vecs[9]  = '{1, 8'h08, 32'hCAFEF00D, 4'hF, 32'h0,        0, 4'b0100};
    vecs[10] = '{0, 8'h08, 32'h0,        4'h0, 32'hCAFEF00D, 0, 4'b0000};
    vecs[11] = '{1, 8'h1C, 32'h55555555, 4'hF, 32'h0,        1, 4'b0000};
    vecs[12] = '{1, 8'h06, 32'h99999999, 4'hF, 32'h0,        1, 4'b0000};

    repeat (3) @(posedge clk);
    #1 preset_n = 1'b1;
    @(negedge clk);
    chk("reset pready", {pready_a, pready_b}, 2'b00);
    chk("reset pslverr", {pslverr_a, pslverr_b}, 2'b00);
    chk("reset prdata", {prdata_a, prdata_b}, 64'h0);
    chk("reset wr_pulse", {wr_pulse_a, wr_pulse_b}, 8'h0);
    chk("reset rw_regs", {rw_a, rw_b}, 256'h0);

    foreach (vecs[i])
      apb(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
          vecs[i].rd, vecs[i].err, vecs[i].pulse, 2);

    // Abort: psel dropped during a wait state must not commit.
    @(posedge clk); #1 psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C;
    pwdata = 32'h77777777; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel_a = 1'b0; penable = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort pready", pready_a, 1'b0);
      chk("abort wr_pulse", wr_pulse_a, 4'h0);
    end
    chk("abort rw_regs", rw_a, mdl_a);

    // Zero-wait back-to-back writes: completions two cycles apart.
    @(posedge clk); #1 psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00;
    pwdata = 32'h00001111; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    chk("b2b ready 1", {pready_b, pslverr_b}, 2'b10);
    @(posedge clk); #1 penable = 1'b0; paddr = 8'h0C; pwdata = 32'h33330000;
    @(negedge clk);
    mdl_b[0] = 32'h00001111;
    chk("b2b setup pready", pready_b, 1'b0);
    chk("b2b pulse 1", wr_pulse_b, 4'b0001);
    chk("b2b rw 1", rw_b, mdl_b);
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    chk("b2b ready 2", {pready_b, pslverr_b}, 2'b10);
    @(posedge clk); #1 psel_b = 1'b0; penable = 1'b0;
    @(negedge clk);
    mdl_b[3] = 32'h33330000;
    chk("b2b pulse 2", wr_pulse_b, 4'b1000);
    chk("b2b rw 2", rw_b, mdl_b);
    apb(1'b1, 1'b0, 8'h0C, 32'h0, 4'h0, 32'h33330000, 1'b0, 4'h0, 0);

    // Reset during a wait state of a write to 0x08.
    @(posedge clk); #1 psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08;
    pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 preset_n = 1'b0;
    @(posedge clk); #1 preset_n = 1'b1;
    mdl_a = '0; mdl_b = '0;
    @(negedge clk);
    chk("rst pready", pready_a, 1'b0);
    chk("rst wr_pulse", wr_pulse_a, 4'h0);
    chk("rst rw_regs", rw_a, mdl_a);
    chk("rst rw_regs b", rw_b, mdl_b);
    // Access phase with no setup right after reset is ignored.
    @(posedge clk); #1 psel_a = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("rst idle pready", pready_a, 1'b0);
    chk("rst idle rw", rw_a, mdl_a);
    apb(1'b0, 1'b1, 8'h08, 32'hABCD0123, 4'hF, 32'h0, 1'b0, 4'b0100, 2);
    apb(1'b0, 1'b0, 8'h08, 32'h0, 4'h0, 32'hABCD0123, 1'b0, 4'h0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
